// File: rtl/linebuf_rd_ctrl_pkg.sv
// Shared types and defaults for the line-buffer read scheduler.
// Banks are indexed 0..3; a burst reads three of them at once.
package linebuf_rd_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_e;

  typedef logic [1:0] bank_t;

  localparam logic [11:0] IMAGE_WIDTH_DEF  = 12'd28;
  localparam logic [10:0] IMAGE_HEIGHT_DEF = 11'd28;
  localparam int          RD_LAT_DEF       = 2;

  // One-hot-of-three enable mask for the banks feeding the window.
  function automatic logic [3:0] bank_mask(input bank_t a, input bank_t b, input bank_t c);
    bank_mask = (4'b0001 << a) | (4'b0001 << b) | (4'b0001 << c);
  endfunction

endpackage

// File: rtl/linebuf_vld_dly.sv
// RD_LAT-deep valid delay line aligning read enables with BRAM data.
// Also strobes the cycle after a tagged valid run ends.
module linebuf_vld_dly
  import linebuf_rd_ctrl_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic clk,
  input  logic RESET_N,
  input  logic clr,
  input  logic vld_in,
  input  logic tag_in,
  output logic vld_out,
  output logic fall_tag
);

  logic [RD_LAT-1:0] vld_sr;
  logic [RD_LAT-1:0] vld_nxt;
  logic [RD_LAT-1:0] tag_sr;
  logic [RD_LAT-1:0] tag_nxt;

  always_comb begin
    vld_nxt    = vld_sr;
    tag_nxt    = tag_sr;
    vld_nxt[0] = vld_in;
    tag_nxt[0] = tag_in;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_nxt[i] = vld_sr[i-1];
      tag_nxt[i] = tag_sr[i-1];
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      vld_sr   <= '0;
      tag_sr   <= '0;
      fall_tag <= 1'b0;
    end else if (clr) begin
      vld_sr   <= '0;
      tag_sr   <= '0;
      fall_tag <= 1'b0;
    end else begin
      vld_sr   <= vld_nxt;
      tag_sr   <= tag_nxt;
      // High in the cycle right after the last tagged valid leaves the line.
      fall_tag <= vld_sr[RD_LAT-1] & tag_sr[RD_LAT-1] & ~vld_nxt[RD_LAT-1];
    end
  end

  assign vld_out = vld_sr[RD_LAT-1];

endmodule

// File: rtl/linebuf_rd_ctrl.sv
// Read-side scheduler for the four-bank rotating line buffer: one W-long
// burst over the three newest complete rows per finished row (from row 2 on).
module linebuf_rd_ctrl
  import linebuf_rd_ctrl_pkg::*;
#(
  parameter logic [11:0] image_width  = IMAGE_WIDTH_DEF,
  parameter logic [10:0] image_height = IMAGE_HEIGHT_DEF,
  parameter int          RD_LAT       = RD_LAT_DEF
) (
  input  logic        clk,
  input  logic        RESET_N,
  input  logic        start_wr,
  input  logic        de_in,
  output logic [10:0] rd_addr,
  output logic        in0_rden,
  output logic        in1_rden,
  output logic        in2_rden,
  output logic        in3_rden,
  output bank_t       win_top,
  output bank_t       win_mid,
  output bank_t       win_bot,
  output logic        de_out,
  output logic [10:0] out_row,
  output logic        frame_done,
  output logic        overflow,
  output rd_state_e   dbg_state
);

  localparam logic [10:0] LAST_ADDR = 11'(image_width - 12'd1);
  localparam logic [11:0] LAST_ROW  = {1'b0, image_height} - 12'd1;
  localparam logic [10:0] FINAL_ROW = image_height - 11'd3;

  rd_state_e   state_q, state_d;
  logic        de_q, row_done_q;
  logic [11:0] wr_row_q, wr_row_d;
  logic [10:0] rd_addr_d;
  logic        pend_q, pend_d;
  logic [10:0] pend_row_q, pend_row_d;
  logic        ovf_d;
  logic        req;
  logic [10:0] req_row;
  logic        start_burst;
  logic [10:0] burst_row;
  logic [3:0]  rden_vec;

  // wr_row_q is the index of the row that row_done_q reports as finished.
  assign req     = row_done_q && (wr_row_q >= 12'd2);
  assign req_row = 11'(wr_row_q - 12'd2);

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr;
    pend_d      = pend_q;
    pend_row_d  = pend_row_q;
    ovf_d       = overflow;
    wr_row_d    = wr_row_q;
    start_burst = 1'b0;
    burst_row   = req_row;
    if (row_done_q) wr_row_d = (wr_row_q == LAST_ROW) ? 12'd0 : wr_row_q + 12'd1;
    if (start_wr) begin
      state_d   = IDLE;
      rd_addr_d = '0;
      pend_d    = 1'b0;
      ovf_d     = 1'b0;
      wr_row_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            state_d     = READ;
            rd_addr_d   = '0;
            start_burst = 1'b1;
          end
        end
        READ: begin
          if (rd_addr == LAST_ADDR) begin
            // Final read: chain straight into the next burst when one is waiting.
            rd_addr_d = '0;
            if (pend_q) begin
              start_burst = 1'b1;
              burst_row   = pend_row_q;
              pend_d      = 1'b0;
              if (req) ovf_d = 1'b1;
            end else if (req) begin
              start_burst = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            rd_addr_d = rd_addr + 11'd1;
            if (req) begin
              if (pend_q) begin
                ovf_d = 1'b1;
              end else begin
                pend_d     = 1'b1;
                pend_row_d = req_row;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      de_q       <= 1'b0;
      row_done_q <= 1'b0;
      wr_row_q   <= '0;
      rd_addr    <= '0;
      pend_q     <= 1'b0;
      pend_row_q <= '0;
      overflow   <= 1'b0;
      win_top    <= '0;
      win_mid    <= '0;
      win_bot    <= '0;
      out_row    <= '0;
    end else begin
      state_q    <= state_d;
      de_q       <= de_in;
      row_done_q <= de_q & ~de_in;
      wr_row_q   <= wr_row_d;
      rd_addr    <= rd_addr_d;
      pend_q     <= pend_d;
      pend_row_q <= pend_row_d;
      overflow   <= ovf_d;
      if (start_burst) begin
        win_top <= burst_row[1:0];
        win_mid <= burst_row[1:0] + 2'd1;
        win_bot <= burst_row[1:0] + 2'd2;
        out_row <= burst_row;
      end
    end
  end

  // Window registers always describe the burst in flight while in READ.
  assign rden_vec  = (state_q == READ) ? bank_mask(win_top, win_mid, win_bot) : 4'b0000;
  assign in0_rden  = rden_vec[0];
  assign in1_rden  = rden_vec[1];
  assign in2_rden  = rden_vec[2];
  assign in3_rden  = rden_vec[3];
  assign dbg_state = state_q;

  linebuf_vld_dly #(
    .RD_LAT(RD_LAT)
  ) u_vld_dly (
    .clk     (clk),
    .RESET_N (RESET_N),
    .clr     (start_wr),
    .vld_in  (state_q == READ),
    .tag_in  ((state_q == READ) && (out_row == FINAL_ROW)),
    .vld_out (de_out),
    .fall_tag(frame_done)
  );

endmodule

// File: doc/linebuf_rd_ctrl.md
Name: linebuf_rd_ctrl

Overview:
Read-side scheduler for the four-bank rotating line buffer (bram_24 x4). The write side fills one bank per incoming row.
This block tracks completed rows and, once three consecutive rows are stored, issues one W-address read burst across the three newest banks. It never reads the bank currently being written.
It drives rd_addr and in0..3_rden, reports the top/mid/bottom bank mapping for the downstream 3x3 window mux, and flags window-row validity and frame end.

Parameters:
image_width, 12'd28, pixels per row (burst length W); legal range 4..2047
image_height, 11'd28, rows per frame (H); legal range 3..2047
RD_LAT, 2, BRAM read latency in clk cycles (rden to q valid); legal range 1..4

Ports:
clk  in  1  system clock, all logic on posedge
RESET_N  in  1  asynchronous active-low reset
start_wr  in  1  synchronous frame restart; same pulse as write side
de_in  in  1  input row-valid, same signal feeding the write side
rd_addr  out  11  read address shared by all banks
in0_rden  out  1  read enable, bank 0 (in1_rden..in3_rden identical, banks 1..3)
win_top  out  2  bank holding oldest row of current window
win_mid  out  2  bank holding middle row
win_bot  out  2  bank holding newest row
de_out  out  1  window-column valid, aligned to BRAM q
out_row  out  11  output row index of current burst, 0..H-3
frame_done  out  1  one-cycle pulse after last de_out of frame
overflow  out  1  sticky: row completion lost

Behaviour:
- Reset (RESET_N=0, async): state IDLE. rd_addr=0, all rden=0, win_*=0, de_out=0, out_row=0, frame_done=0, overflow=0. Row counter, pending flag and delay line cleared.
- row_done: registered falling edge of de_in (de_q & ~de_in), one cycle after de_in falls.
- wr_row (12b): +1 on each row_done; wraps H-1 -> 0. Value r = index of the row just completed.
- Burst request: row_done with r >= 2. Latch top=(r-2)[1:0], mid=(r-1)[1:0], bot=r[1:0], out_row=r-2.
- IDLE:
  - request -> READ on next cycle, rd_addr=0.
  - rden asserted for banks top/mid/bot only; fourth bank rden=0.
- READ:
  - rd_addr increments by 1 each cycle.
  - At rd_addr==W-1, the last read is issued. Next state: READ (rd_addr=0, new mapping) if pending, else IDLE (rden=0, rd_addr=0).
  - The back-to-back case has no bubble.
- Pending: one-deep.
  - A request arriving while in READ sets pending and stores its mapping.
  - A request while pending already set sets overflow (sticky) and is dropped.
  - A request coinciding with the final READ cycle is treated as pending.
- win_* and out_row update only when a burst starts; they hold otherwise.
- de_out: OR of rden delayed RD_LAT cycles via shift register, independent of state. Exactly W cycles high per burst.
- frame_done: pulse on the falling edge of delayed de_out for the burst with out_row==H-3. wr_row has already wrapped, so the next frame starts cleanly.
- start_wr=1 (sync, highest priority after reset):
  - state IDLE, rden=0 next cycle, rd_addr=0.
  - wr_row, pending, overflow and delay line cleared; de_out=0 next cycle.
  - A simultaneous row_done is ignored.
- Rows shorter than W with period < W+1 cause pending/overflow. That is legal stimulus, not an error in the block.
- Width rules:
  - rd_addr compared against image_width-1 truncated to 11 bits.
  - Counters are unsigned, no saturation.

Decomposition:
- Shared package: state encoding (IDLE, READ), bank index type (2b), image_width/image_height defaults, RD_LAT default.
- One sub-module is natural: linebuf_vld_dly. It is an RD_LAT-deep shift register producing de_out and its falling-edge strobe for frame_done.

Test Plan:
- Reset: assert RESET_N=0 mid-burst -> all outputs 0 immediately; after release no rden until 3 rows complete.
- Rows 0,1 (28-cycle de_in, 4-cycle gap):
  - No rden.
  - After row 2, rden banks 0,1,2 (in3_rden=0) for 28 cycles, 2 cycles after de_in falls.
  - rd_addr 0..27, win_top/mid/bot=0/1/2, out_row=0.
  - de_out high 28 cycles starting 2 cycles after first rden.
- Row 4 completes -> banks 2,3,0 read (in1_rden=0), win=2/3/0, out_row=2. No rden ever on the bank whose row is in progress.
- Full 28x28 frame:
  - Exactly 26 bursts, out_row 0..25, one frame_done pulse after final de_out.
  - Next frame's first burst occurs only after its 3rd row.
- Short rows (de_in 10 cycles, gap 1):
  - 2nd request during burst -> pending, next burst starts the cycle after rd_addr=27 with no gap.
  - 3rd request before then -> overflow=1 and stays 1.
- start_wr at rd_addr=12 -> next cycle all rden=0, rd_addr=0, overflow=0, de_out drops. The next burst waits for 3 fresh rows.
